// File: rtl/if_fetch.sv
// Instruction-fetch stage: walks the PC, gathers four byte reads into a
// little-endian word and offers {pc, inst} to decode over valid/ready.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_din_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              id_ready_i,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       inst_o
);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_B4   = 3'd4,
    S_HOLD = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [23:0]         byte_buf, byte_buf_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic                mem_rd_n;
  logic                inst_valid_n;
  logic [ADDR_W-1:0]   pc_out_n;
  logic [31:0]         inst_n;

  // Redirect targets are word aligned; the low two bits carry no meaning.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_B0;
    end else begin
      state <= state_n;
    end
  end

  // Each state registers the memory request it issues, so the address is
  // visible one state later and its byte is captured at the end of that state.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    byte_buf_n   = byte_buf;
    mem_addr_n   = mem_addr_o;
    mem_rd_n     = mem_rd_o;
    inst_valid_n = inst_valid_o;
    pc_out_n     = pc_o;
    inst_n       = inst_o;
    if (redirect_i) begin
      state_n      = S_B0;
      pc_n         = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      mem_rd_n     = 1'b0;
      inst_valid_n = 1'b0;
    end else begin
      case (state)
        S_B0: begin
          mem_addr_n = pc;
          mem_rd_n   = 1'b1;
          state_n    = S_B1;
        end
        S_B1: begin
          byte_buf_n[7:0] = mem_din_i;
          mem_addr_n      = pc + ADDR_W'(1);
          state_n         = S_B2;
        end
        S_B2: begin
          byte_buf_n[15:8] = mem_din_i;
          mem_addr_n       = pc + ADDR_W'(2);
          state_n          = S_B3;
        end
        S_B3: begin
          byte_buf_n[23:16] = mem_din_i;
          mem_addr_n        = pc + ADDR_W'(3);
          state_n           = S_B4;
        end
        S_B4: begin
          mem_rd_n     = 1'b0;
          inst_n       = {mem_din_i, byte_buf};
          pc_out_n     = pc;
          inst_valid_n = 1'b1;
          state_n      = S_HOLD;
        end
        S_HOLD: begin
          if (id_ready_i) begin
            inst_valid_n = 1'b0;
            pc_n         = pc + ADDR_W'(4);
            state_n      = S_B0;
          end
        end
        default: begin
          state_n = S_B0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      byte_buf     <= '0;
      mem_addr_o   <= '0;
      mem_rd_o     <= 1'b0;
      inst_valid_o <= 1'b0;
      pc_o         <= '0;
      inst_o       <= '0;
    end else begin
      pc           <= pc_n;
      byte_buf     <= byte_buf_n;
      mem_addr_o   <= mem_addr_n;
      mem_rd_o     <= mem_rd_n;
      inst_valid_o <= inst_valid_n;
      pc_o         <= pc_out_n;
      inst_o       <= inst_n;
    end
  end

endmodule
